// File: rtl/cache_axi_bridge_if.sv
// AXI3/AXI4 master-side bus bundle for cache_axi_bridge.
// The bridge uses the master modport; the interconnect (or a bench) uses slave.
// With AXI_RESP_CHECK_EN defined, the read and write response codes are carried too.
interface cache_axi_bridge_if;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;
`ifdef AXI_RESP_CHECK_EN
  logic [1:0]   rresp;
  logic [1:0]   bresp;
`endif

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
`ifdef AXI_RESP_CHECK_EN
    ,
    input  rresp, bresp
`endif
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
`ifdef AXI_RESP_CHECK_EN
    ,
    output rresp, bresp
`endif
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache miss interface to AXI master bridge.
// Independent read and write FSMs; a read to a line that a write is currently
// carrying (or is being accepted this cycle) is held off until the B response.
// Optional macro AXI_RESP_CHECK_EN: adds rresp/bresp on the bus bundle and a
// sticky bus_err output set by any non-OKAY response.
//
// state  | meaning
// R_IDLE | ready for a cache read request (unless hazard)
// R_AR   | read address presented, waiting for arready
// R_DATA | accepting read beats, passed straight through to the cache
// W_IDLE | ready for a cache write request
// W_AW   | write address presented, waiting for awready
// W_DATA | sending write beats from the latched line buffer
// W_RESP | waiting for the B response
module cache_axi_bridge #(
  parameter logic [3:0] AR_ID = 4'd0,
  parameter logic [3:0] AW_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  cache_axi_bridge_if.master axi
`ifdef AXI_RESP_CHECK_EN
  ,
  output logic         bus_err
`endif
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  localparam logic [2:0] TYPE_LINE = 3'b100;

  r_state_t       r_state;
  w_state_t       w_state;
  logic [127:0]   wbuf;
  logic [1:0]     wcnt;
  logic [1:0]     wbase;
  logic [1:0]     widx;
  logic           hazard;

  // Byte/half/word map to their natural size; lines and unknown codes use word size.
  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b010: size_of = {1'b0, t[1:0]};
      default:                size_of = 3'd2;
    endcase
  endfunction

  assign axi.arid    = AR_ID;
  assign axi.arburst = 2'b01;
  assign axi.awid    = AW_ID;
  assign axi.awburst = 2'b01;

  // Read-after-write hold-off on a matching 16B line, including a write being accepted now.
  assign wr_rdy = (w_state == W_IDLE);
  assign hazard = ((w_state != W_IDLE) && (rd_addr[31:4] == axi.awaddr[31:4])) ||
                  (wr_req && wr_rdy && (rd_addr[31:4] == wr_addr[31:4]));
  assign rd_rdy = (r_state == R_IDLE) && !hazard;

  assign ret_valid = axi.rvalid && (r_state == R_DATA);
  assign ret_last  = ret_valid && axi.rlast;
  assign ret_data  = axi.rdata;

  assign widx      = wcnt + wbase;
  assign axi.wdata = wbuf[{widx, 5'b00000} +: 32];
  assign axi.wlast = axi.wvalid && (wcnt == axi.awlen[1:0]);

  // Read FSM: latch request, present AR until accepted, then pass beats through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arsize  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_req && rd_rdy) begin
            r_state     <= R_AR;
            axi.arvalid <= 1'b1;
            if (rd_type == TYPE_LINE) begin
              axi.araddr <= {rd_addr[31:4], 4'b0000};
              axi.arlen  <= 8'd3;
              axi.arsize <= 3'd2;
            end else begin
              axi.araddr <= rd_addr;
              axi.arlen  <= 8'd0;
              axi.arsize <= size_of(rd_type);
            end
          end
        end
        R_AR: begin
          if (axi.arready) begin
            r_state     <= R_DATA;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (axi.rvalid && axi.rlast) begin
            r_state    <= R_IDLE;
            axi.rready <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: latch request and line buffer, AW, data beats, then B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state     <= W_IDLE;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awlen   <= '0;
      axi.awsize  <= '0;
      axi.wstrb   <= '0;
      wbuf        <= '0;
      wcnt        <= '0;
      wbase       <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_req && wr_rdy) begin
            w_state     <= W_AW;
            axi.awvalid <= 1'b1;
            wbuf        <= wr_data;
            wcnt        <= 2'd0;
            if (wr_type == TYPE_LINE) begin
              axi.awaddr <= {wr_addr[31:4], 4'b0000};
              axi.awlen  <= 8'd3;
              axi.awsize <= 3'd2;
              axi.wstrb  <= 4'hf;
              wbase      <= 2'd0;
            end else begin
              axi.awaddr <= wr_addr;
              axi.awlen  <= 8'd0;
              axi.awsize <= size_of(wr_type);
              axi.wstrb  <= wr_wstrb;
              wbase      <= wr_addr[3:2];
            end
          end
        end
        W_AW: begin
          if (axi.awready) begin
            w_state     <= W_DATA;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b1;
          end
        end
        W_DATA: begin
          if (axi.wready) begin
            if (axi.wlast) begin
              w_state    <= W_RESP;
              axi.wvalid <= 1'b0;
              axi.bready <= 1'b1;
            end else begin
              wcnt <= wcnt + 2'd1;
            end
          end
        end
        W_RESP: begin
          if (axi.bvalid) begin
            w_state    <= W_IDLE;
            axi.bready <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

`ifdef AXI_RESP_CHECK_EN
  // Sticky error flag: any non-OKAY R or B response, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((axi.rvalid && axi.rready && (axi.rresp != 2'b00)) ||
                 (axi.bvalid && axi.bready && (axi.bresp != 2'b00))) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Self-checking bench for cache_axi_bridge: scoreboard queues hold expected
// read-return and write-data beats; bench plays the AXI slave.
module tb_cache_axi_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
`ifdef AXI_RESP_CHECK_EN
  logic         bus_err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] rd_exp_q[$];
  logic [31:0] wr_exp_q[$];
  logic [3:0]  exp_wstrb;
  bit          hz_watch = 1'b0;

  always #5 clk = ~clk;

  cache_axi_bridge_if axi();

  cache_axi_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .axi       (axi.master)
`ifdef AXI_RESP_CHECK_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hz_chk();
    if (hz_watch) begin
      chk("hz_rd_rdy", rd_rdy, 1'b0);
      chk("hz_arvalid", axi.arvalid, 1'b0);
    end
  endtask

  task automatic r_accept(input logic [31:0] a, input logic [2:0] t);
    int n = 0;
    rd_req = 1'b1; rd_addr = a; rd_type = t;
    #3;
    while (!rd_rdy && n < 50) begin cyc(); #3; n++; end
    chk("rd_rdy", rd_rdy, 1'b1);
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic r_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input int dly);
    axi.arready = 1'b0;
    #3;
    chk("arvalid", axi.arvalid, 1'b1);
    chk("araddr", axi.araddr, a);
    chk("arlen", axi.arlen, l);
    chk("arsize", axi.arsize, s);
    chk("arburst", axi.arburst, 2'b01);
    chk("arid", axi.arid, 4'd0);
    for (int i = 0; i < dly; i++) begin
      cyc(); #3;
      chk("arvalid_hold", axi.arvalid, 1'b1);
      chk("araddr_hold", axi.araddr, a);
    end
    cyc();
    axi.arready = 1'b1;
    #3;
    cyc();
    axi.arready = 1'b0;
  endtask

  task automatic r_data(input int n);
    int k = 0;
    int it = 0;
    logic [31:0] d;
    while (k < n && it < 64) begin
      it++;
      axi.rvalid = ($urandom_range(0, 3) != 0);
      axi.rlast  = 1'b0;
      d = $urandom;
      axi.rdata = d;
      if (axi.rvalid) begin
        axi.rlast = (k == n - 1);
        rd_exp_q.push_back(d);
      end
      #3;
      chk("rready", axi.rready, 1'b1);
      chk("ret_valid", ret_valid, axi.rvalid);
      if (ret_valid) begin
        chk("rd_sb_depth", rd_exp_q.size() != 0, 1'b1);
        if (rd_exp_q.size() != 0) chk("ret_data", ret_data, rd_exp_q.pop_front());
        chk("ret_last", ret_last, k == n - 1);
        k++;
      end
      cyc();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    chk("rd_beats", k, n);
    #3;
    chk("rready_off", axi.rready, 1'b0);
    chk("rd_rdy_back", rd_rdy, 1'b1);
    cyc();
  endtask

  // Expected write beats: whole line in order, or the single addressed word.
  task automatic w_model(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                         input logic [127:0] d);
    if (t == 3'b100) begin
      for (int k = 0; k < 4; k++) wr_exp_q.push_back(d[32*k +: 32]);
      exp_wstrb = 4'hf;
    end else begin
      wr_exp_q.push_back(d[32*a[3:2] +: 32]);
      exp_wstrb = s;
    end
  endtask

  task automatic w_accept(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [127:0] d);
    int n = 0;
    wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s; wr_data = d;
    w_model(a, t, s, d);
    #3;
    while (!wr_rdy && n < 50) begin cyc(); #3; n++; end
    chk("wr_rdy", wr_rdy, 1'b1);
    hz_chk();
    cyc();
    wr_req = 1'b0;
  endtask

  task automatic w_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input int dly);
    axi.awready = 1'b0;
    #3;
    chk("awvalid", axi.awvalid, 1'b1);
    chk("awaddr", axi.awaddr, a);
    chk("awlen", axi.awlen, l);
    chk("awsize", axi.awsize, s);
    chk("awid", axi.awid, 4'd1);
    hz_chk();
    for (int i = 0; i < dly; i++) begin
      cyc(); #3;
      chk("awvalid_hold", axi.awvalid, 1'b1);
      hz_chk();
    end
    cyc();
    axi.awready = 1'b1;
    #3;
    cyc();
    axi.awready = 1'b0;
  endtask

  task automatic w_data(input bit toggle);
    int i = 0;
    while (wr_exp_q.size() != 0 && i < 64) begin
      axi.wready = toggle ? (i % 2 == 0) : 1'b1;
      i++;
      #3;
      chk("wvalid", axi.wvalid, 1'b1);
      chk("wdata", axi.wdata, wr_exp_q[0]);
      chk("wstrb", axi.wstrb, exp_wstrb);
      chk("wlast", axi.wlast, wr_exp_q.size() == 1);
      hz_chk();
      if (axi.wready) void'(wr_exp_q.pop_front());
      cyc();
    end
    axi.wready = 1'b0;
    chk("wr_beats_left", wr_exp_q.size(), 0);
  endtask

  task automatic w_resp(input int dly);
    #3;
    chk("bready", axi.bready, 1'b1);
    chk("wvalid_off", axi.wvalid, 1'b0);
    chk("wr_rdy_busy", wr_rdy, 1'b0);
    hz_chk();
    for (int i = 0; i < dly; i++) begin
      cyc(); #3;
      chk("bready_hold", axi.bready, 1'b1);
      hz_chk();
    end
    cyc();
    axi.bvalid = 1'b1;
    #3;
    hz_chk();
    cyc();
    axi.bvalid = 1'b0;
    #3;
    chk("wr_rdy_back", wr_rdy, 1'b1);
    chk("bready_off", axi.bready, 1'b0);
    if (hz_watch) chk("hz_release", rd_rdy, 1'b1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line;
    logic [31:0]  x1;
    rst = 1'b1;
    rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
`ifdef AXI_RESP_CHECK_EN
    axi.rresp = 2'b00; axi.bresp = 2'b00;
`endif
    repeat (3) cyc();
    rst = 1'b0;
    #3;
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_ret_valid", ret_valid, 1'b0);
    chk("rst_rd_rdy", rd_rdy, 1'b1);
    chk("rst_wr_rdy", wr_rdy, 1'b1);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_awlen", axi.awlen, 8'h0);
`ifdef AXI_RESP_CHECK_EN
    chk("rst_bus_err", bus_err, 1'b0);
`endif
    cyc();

    // Line read with two-cycle AR stall.
    r_accept(32'h1C00_0014, 3'b100);
    r_ar(32'h1C00_0010, 8'd3, 3'd2, 2);
    r_data(4);

    // Halfword and unknown-type single reads.
    r_accept(32'h0000_0102, 3'b001);
    r_ar(32'h0000_0102, 8'd0, 3'd1, 0);
    r_data(1);
    r_accept(32'h4000_0008, 3'b111);
    r_ar(32'h4000_0008, 8'd0, 3'd2, 1);
    r_data(1);

    // Single byte write to word 2.
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h0000_0008, 3'b000, 4'b0100, line);
    w_aw(32'h0000_0008, 8'd0, 3'd0, 1);
    w_data(1'b0);
    w_resp(2);

    // Line write with wready toggling.
    w_accept(32'h0000_0104, 3'b100, 4'h0,
             {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    w_aw(32'h0000_0100, 8'd3, 3'd2, 0);
    w_data(1'b1);
    w_resp(0);

    // Word write at word 1.
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h0000_0104, 3'b010, 4'hf, line);
    w_aw(32'h0000_0104, 8'd0, 3'd2, 0);
    w_data(1'b1);
    w_resp(1);

    // Read to the line being written waits for the B response.
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h2000_0040, 3'b100, 4'h0, line);
    w_aw(32'h2000_0040, 8'd3, 3'd2, 0);
    rd_req = 1'b1; rd_addr = 32'h2000_0048; rd_type = 3'b100;
    hz_watch = 1'b1;
    w_data(1'b1);
    w_resp(1);
    rd_req = 1'b0;
    hz_watch = 1'b0;
    r_ar(32'h2000_0040, 8'd3, 3'd2, 0);
    r_data(4);

    // Read to a different line during a write is accepted immediately.
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h2000_0040, 3'b100, 4'h0, line);
    w_aw(32'h2000_0040, 8'd3, 3'd2, 0);
    rd_req = 1'b1; rd_addr = 32'h2000_0080; rd_type = 3'b100;
    #3;
    chk("no_hz_rd_rdy", rd_rdy, 1'b1);
    cyc();
    rd_req = 1'b0;
    r_ar(32'h2000_0080, 8'd3, 3'd2, 0);
    r_data(4);
    w_data(1'b0);
    w_resp(0);

    // Same-cycle read and write to the same line: write wins, read waits.
    rd_req = 1'b1; rd_addr = 32'h6000_0004; rd_type = 3'b010;
    hz_watch = 1'b1;
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h6000_0008, 3'b100, 4'h0, line);
    w_aw(32'h6000_0000, 8'd3, 3'd2, 0);
    w_data(1'b0);
    w_resp(0);
    rd_req = 1'b0;
    hz_watch = 1'b0;
    r_ar(32'h6000_0004, 8'd0, 3'd2, 0);
    r_data(1);

    // Same-cycle read and write to different lines: both accepted.
    line = {$urandom, $urandom, $urandom, $urandom};
    rd_req = 1'b1; rd_addr = 32'h5000_0000; rd_type = 3'b100;
    wr_req = 1'b1; wr_addr = 32'h5000_0010; wr_type = 3'b100; wr_wstrb = 4'h0; wr_data = line;
    w_model(32'h5000_0010, 3'b100, 4'h0, line);
    #3;
    chk("dual_rd_rdy", rd_rdy, 1'b1);
    chk("dual_wr_rdy", wr_rdy, 1'b1);
    cyc();
    rd_req = 1'b0; wr_req = 1'b0;
    r_ar(32'h5000_0000, 8'd3, 3'd2, 0);
    r_data(4);
    w_aw(32'h5000_0010, 8'd3, 3'd2, 0);
    w_data(1'b1);
    w_resp(1);

    // Reset during the second beat of a line read.
    r_accept(32'h7000_0000, 3'b100);
    r_ar(32'h7000_0000, 8'd3, 3'd2, 0);
    x1 = $urandom;
    axi.rvalid = 1'b1; axi.rdata = x1; axi.rlast = 1'b0;
    #3;
    chk("rb_beat1", ret_data, x1);
    cyc();
    axi.rdata = $urandom;
    rst = 1'b1;
    #3;
    cyc();
    rst = 1'b0;
    #3;
    chk("rb_rready", axi.rready, 1'b0);
    chk("rb_arvalid", axi.arvalid, 1'b0);
    chk("rb_ret_valid", ret_valid, 1'b0);
    chk("rb_rd_rdy", rd_rdy, 1'b1);
    chk("rb_wr_rdy", wr_rdy, 1'b1);
    axi.rvalid = 1'b0;
    cyc();

`ifdef AXI_RESP_CHECK_EN
    // Sticky bus error on SLVERR write response.
    chk("be_clear", bus_err, 1'b0);
    axi.bresp = 2'b10;
    line = {$urandom, $urandom, $urandom, $urandom};
    w_accept(32'h0000_0008, 3'b000, 4'b0100, line);
    w_aw(32'h0000_0008, 8'd0, 3'd0, 0);
    w_data(1'b0);
    w_resp(0);
    #3;
    chk("be_set", bus_err, 1'b1);
    cyc();
    axi.bresp = 2'b00;
    w_accept(32'h0000_0000, 3'b100, 4'h0, line);
    w_aw(32'h0000_0000, 8'd3, 3'd2, 0);
    w_data(1'b0);
    w_resp(0);
    #3;
    chk("be_sticky", bus_err, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #3;
    chk("be_rst", bus_err, 1'b0);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Responder side of the cache miss interface: accepts `rd_req`/`wr_req` line and single-word requests from one cache and turns them into AXI3/AXI4 master transactions.
- Returns read beats as `ret_valid`/`ret_last`/`ret_data`.
- Sits between the cache and the SoC AXI interconnect.
- Read and write paths are independent FSMs, with a read-after-write line hazard check between them.

Parameters:
- AR_ID, 4'd0, value driven on `arid`
- AW_ID, 4'd1, value driven on `awid`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  read request from cache
- rd_type  in  3  3'b100 = 16B line; 3'b000/001/010 = byte/half/word
- rd_addr  in  32  read address
- rd_rdy  out  1  read request accepted this cycle when high with `rd_req`
- ret_valid  out  1  read beat valid
- ret_last  out  1  last read beat
- ret_data  out  32  read beat data
- wr_req  in  1  write request from cache
- wr_type  in  3  same encoding as `rd_type`
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe for single writes
- wr_data  in  128  line data; word k at bits [32k+31:32k]
- wr_rdy  out  1  write request accepted this cycle when high with `wr_req`
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1  AXI AR channel
- arready  in  1
- rdata  in  32, rlast  in  1, rvalid  in  1; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1  AXI AW channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready  in  1
- bvalid  in  1; bready  out  1

Behaviour:
- Reset values: all AXI `*valid`, `rready`, `bready`, `ret_valid`, `ret_last` = 0. States = R_IDLE/W_IDLE, so `rd_rdy` = `wr_rdy` = 1 the cycle after reset (subject to hazard). Address/len registers = 0.
- Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
  - `rd_rdy` = (R_IDLE) & ~hazard.
  - On `rd_req & rd_rdy`, latch the request and go to R_AR.
  - Line request: `araddr` = {addr[31:4],4'b0}, `arlen` = 3, `arsize` = 2.
  - Single request: `araddr` = addr, `arlen` = 0, `arsize` = {1'b0, type[1:0]}.
  - `arburst` = 2'b01 always.
  - `arvalid` held until `arready`, then go to R_DATA. The AR address is stable while valid.
  - R_DATA: `rready` = 1. `ret_valid` = `rvalid` & R_DATA, `ret_last` = `rlast`, `ret_data` = `rdata`, all combinational with zero-cycle latency. The cache must always accept beats.
  - `rvalid & rlast` in R_DATA -> R_IDLE. The next `rd_req` can be accepted in the following cycle.
- Write FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
  - `wr_rdy` = (W_IDLE).
  - On `wr_req & wr_rdy`, latch addr, type, strobe and the 128-bit buffer.
  - Line write: `awaddr` aligned to 16B, `awlen` = 3, `awsize` = 2, `wstrb` = 4'hf.
  - Single write: `awaddr` = addr, `awlen` = 0, `awsize` = {1'b0, type[1:0]}, `wstrb` = latched `wr_wstrb`.
  - `awvalid` held until `awready`, then go to W_DATA.
  - W_DATA: `wvalid` = 1. 2-bit beat counter starts at 0; `wdata` = buf[32*cnt +: 32]. Single writes send buffer word addr[3:2].
  - `wlast` = (cnt == `awlen`[1:0]). Counter advances only on `wvalid & wready`.
  - Last handshake -> W_RESP: `bready` = 1. `bvalid` -> W_IDLE.
- Hazard (read after write): hazard = 1 when either condition holds:
  - W state ≠ W_IDLE and `rd_addr`[31:4] == latched `wr_addr`[31:4];
  - or `wr_req & wr_rdy` this cycle with `rd_addr`[31:4] == `wr_addr`[31:4].
  - The read waits until the write's B response completes.
- Simultaneous `rd_req` and `wr_req` to different lines in the same cycle: both accepted that cycle, and the two channels proceed independently.
- `rd_type`/`wr_type` values other than 000/001/010/100: treated as word (`arsize` = 2, `arlen` = 0).
- Reset mid-burst: FSMs return to idle the next cycle and all valids drop. The interconnect shares `rst`, so no transaction completion is attempted.

Optional Feature:
- Macro AXI_RESP_CHECK_EN.
- Defined:
  - Adds inputs `rresp[1:0]`, `bresp[1:0]` and output `bus_err` (1 bit).
  - `bus_err` sets sticky on any `rvalid & rready` or `bvalid & bready` with resp ≠ 2'b00.
  - `bus_err` clears only on `rst`; reset value 0.
  - Data flow is unchanged.
- Undefined: those ports do not exist and responses are ignored.

Test Plan:
- Line read, `rd_addr` = 0x1C00_0014, `arready` after 2 cycles:
  - `araddr` = 0x1C00_0010, `arlen` = 3, `arsize` = 2.
  - 4 `ret_valid` beats mirror `rdata`; `ret_last` on beat 4; `rd_rdy` = 1 next cycle.
- Single byte write, `wr_addr` = 0x8, `wr_wstrb` = 4'b0100, `wr_type` = 000:
  - `awlen` = 0, `awsize` = 0.
  - One beat, `wdata` = buf word 2, `wstrb` = 4'b0100, `wlast` = 1.
  - `wr_rdy` returns after `bvalid`.
- Line write, `wr_data` = {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA}, `wready` toggling 1/0:
  - Beats 0xAAAA_AAAA, 0xBBBB_BBBB, 0xCCCC_CCCC, 0xDDDD_DDDD in order, each held while stalled.
  - `wlast` on the 4th beat only.
- Line write to 0x2000_0040 in W_DATA, then `rd_req` to 0x2000_0048:
  - `rd_rdy` = 0 until the cycle after the `bvalid` handshake; `arvalid` never precedes `bvalid`.
  - `rd_req` to 0x2000_0080 in the same situation is accepted immediately.
- `rst` asserted during beat 2 of a line read:
  - Next cycle `rready` = `arvalid` = `ret_valid` = 0, `rd_rdy` = `wr_rdy` = 1.
- With AXI_RESP_CHECK_EN defined, `bresp` = 2'b10 on a write:
  - `bus_err` = 1 the next cycle and stays 1 through later OKAY responses until `rst`.
